kintex_adaptive_healer_mc: RTL

Multi-channel adaptive SEFI healer for the Kintex UltraScale fabric: captures single-event functional-interrupt flags from N monitored regions and vetoes downstream outputs for a programmable window. It then sequences one partial reconfiguration (DPR) per faulted region through a start/done handshake with a timeout. Failed or timed-out repairs are retried up to a limit, then escalate to a sticky full-reconfiguration request. The block sits between the per-region SEFI detectors and the DPR controller, replacing the single-channel healer.

---
 rtl/kintex_adaptive_healer_mc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/kintex_adaptive_healer_mc.sv
// Multi-channel SEFI healer: captures per-region fault edges and vetoes outputs.
// It then runs one DPR attempt per faulted region, retries failures, and escalates to full reconfig.
module kintex_adaptive_healer_mc #(
  parameter int N_CH        = 4,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int VETO_CYCLES = 16,
  parameter int DPR_TIMEOUT = 12_500_000,
  parameter int TO_W        = 24,
  parameter int MAX_RETRY   = 3,
  localparam int RC_W       = $clog2(MAX_RETRY + 1)
) (
  input  logic            clk_500mhz,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sefi_flag,
  input  logic            dpr_done,
  input  logic            dpr_ok,
  output logic            dpr_start,
  output logic [CH_W-1:0] dpr_region,
  output logic            veto_pulse,
  output logic            healer_busy,
  output logic [N_CH-1:0] sefi_pending,
  output logic [RC_W-1:0] retry_cnt,
  output logic            escalate
);

  localparam int VC_W = (VETO_CYCLES > 1) ? $clog2(VETO_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VETO,
    S_START,
    S_WAIT,
    S_ESCALATE
  } state_t;

  state_t          state;
  logic [N_CH-1:0] sefi_prev;
  logic [N_CH-1:0] sefi_rise;
  logic [N_CH-1:0] clr_mask;
  logic [VC_W-1:0] veto_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [CH_W-1:0] low_idx;
  logic [RC_W-1:0] retry_next;
  logic            repair_ok;
  logic            timeout_hit;
  logic            attempt_fail;

  assign sefi_rise    = sefi_flag & ~sefi_prev;
  assign repair_ok    = (state == S_WAIT) && dpr_done && dpr_ok;
  assign timeout_hit  = (to_cnt == TO_W'(DPR_TIMEOUT - 1));
  // A done pulse on the timeout cycle is honoured, so the timeout only fails without done.
  assign attempt_fail = (state == S_WAIT) && (dpr_done ? !dpr_ok : timeout_hit);
  assign retry_next   = retry_cnt + RC_W'(1);
  assign clr_mask     = repair_ok ? (N_CH'(1) << dpr_region) : '0;

  // NOTE: the default assignment ahead of the loop keeps this block free of inferred latches.
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (sefi_pending[i]) low_idx = CH_W'(i);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_500mhz) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sefi_prev    <= '0;
      sefi_pending <= '0;
      veto_cnt     <= '0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      dpr_region   <= '0;
      dpr_start    <= 1'b0;
      veto_pulse   <= 1'b0;
      healer_busy  <= 1'b0;
      escalate     <= 1'b0;
    end else begin
      sefi_prev    <= sefi_flag;
      // New edges win over the clear of the region just repaired.
      sefi_pending <= (sefi_pending & ~clr_mask) | sefi_rise;
      dpr_start    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|sefi_pending) begin
            dpr_region  <= low_idx;
            veto_cnt    <= '0;
            veto_pulse  <= 1'b1;
            healer_busy <= 1'b1;
            state       <= S_VETO;
          end
        end

        S_VETO: begin
          if (veto_cnt == VC_W'(VETO_CYCLES - 1)) begin
            veto_pulse <= 1'b0;
            dpr_start  <= 1'b1;
            state      <= S_START;
          end else begin
            veto_cnt <= veto_cnt + VC_W'(1);
          end
        end

        S_START: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (repair_ok) begin
            retry_cnt   <= '0;
            healer_busy <= 1'b0;
            state       <= S_IDLE;
          end else if (attempt_fail) begin
            retry_cnt  <= retry_next;
            veto_pulse <= 1'b1;
            if (retry_next == RC_W'(MAX_RETRY)) begin
              escalate <= 1'b1;
              state    <= S_ESCALATE;
            end else begin
              veto_cnt <= '0;
              state    <= S_VETO;
            end
          end
        end

        S_ESCALATE: begin
          // Terminal until reset; fault capture keeps running above.
          veto_pulse <= 1'b1;
          escalate   <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
